// File: rtl/soc_system_audio_output.sv
// soc_system_audio_output: Avalon-MM audio sample FIFO released to the codec one sample per sample_tick
module soc_system_audio_output #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int LOW_WATER  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write,
  input  logic [31:0]           writedata,
  input  logic                  read,
  output logic [31:0]           readdata,
  input  logic                  sample_tick,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  out_strobe,
  output logic                  irq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;
  localparam logic [LEVEL_W-1:0] FULL_LVL = LEVEL_W'(DEPTH);
  localparam logic [LEVEL_W-1:0] LOW_LVL = LEVEL_W'(LOW_WATER);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LEVEL_W-1:0] level, level_nxt;
  logic enable, irq_en, ovf, udf;
  logic [15:0] urun_cnt, cnt_base;
  logic full, empty, push_req, pop_req, push_ok, do_push, do_pop, underrun;
  logic ctrl_wr, stat_wr, cnt_wr, flush;
  logic [31:0] rd_mux;
  // Decode bus strobes and derive push/pop/underrun from the pre-cycle FIFO state
  always_comb begin
    full = level == FULL_LVL;
    empty = level == '0;
    push_req = chipselect & write & (address == 2'd0);
    stat_wr = chipselect & write & (address == 2'd1);
    ctrl_wr = chipselect & write & (address == 2'd2);
    cnt_wr = chipselect & write & (address == 2'd3);
    flush = ctrl_wr & writedata[1];
    pop_req = sample_tick & enable & !empty;
    underrun = sample_tick & enable & empty;
    push_ok = push_req & (!full | pop_req);
    do_push = push_ok & !flush;
    do_pop = pop_req & !flush;
    level_nxt = flush ? '0 : level + LEVEL_W'(do_push) - LEVEL_W'(do_pop);
    cnt_base = cnt_wr ? 16'd0 : urun_cnt;
    rd_mux = address == 2'd0 ? 32'(out_port)
           : address == 2'd1 ? (32'(level) | {12'd0, empty, full, udf, ovf, 16'd0})
           : address == 2'd2 ? {29'd0, irq_en, 1'b0, enable}
           : {16'd0, urun_cnt};
  end
  // Sample storage; contents need no reset since level/pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= writedata[DATA_WIDTH-1:0];
  end
  // Pointers, level, control, sticky flags, underrun counter and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      enable <= 1'b0;
      irq_en <= 1'b0;
      ovf <= 1'b0;
      udf <= 1'b0;
      urun_cnt <= '0;
      out_port <= '0;
      out_strobe <= 1'b0;
      irq <= 1'b0;
      readdata <= '0;
    end else begin
      wr_ptr <= flush ? '0 : wr_ptr + PTR_W'(do_push);
      rd_ptr <= flush ? '0 : rd_ptr + PTR_W'(do_pop);
      level <= level_nxt;
      if (ctrl_wr) begin
        enable <= writedata[0];
        irq_en <= writedata[2];
      end
      ovf <= (push_req & full & !pop_req) | (ovf & !(stat_wr & writedata[16]));
      udf <= underrun | (udf & !(stat_wr & writedata[17]));
      urun_cnt <= underrun ? (cnt_base == 16'hFFFF ? cnt_base : cnt_base + 16'd1) : cnt_base;
      if (do_pop) out_port <= mem[rd_ptr];
      out_strobe <= do_pop;
      irq <= irq_en & enable & (level < LOW_LVL);
      if (chipselect & read) readdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_soc_system_audio_output.sv
// tb_soc_system_audio_output: directed scoreboard bench for the audio output FIFO
module tb_soc_system_audio_output;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] address = '0;
  logic chipselect = 1'b0;
  logic write = 1'b0;
  logic [31:0] writedata = '0;
  logic read = 1'b0;
  logic [31:0] readdata;
  logic sample_tick = 1'b0;
  logic [31:0] out_port;
  logic out_strobe;
  logic irq;
  logic [31:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;
  int strobes = 0;
  always #5 clk = ~clk;
  soc_system_audio_output dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .read(read), .readdata(readdata),
    .sample_tick(sample_tick), .out_port(out_port), .out_strobe(out_strobe), .irq(irq)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    if (out_strobe === 1'b1) begin
      strobes++;
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL strobe_unexpected: observed out_port %h expected no strobe", out_port);
      end
      if (exp_q.size() != 0) chk("sample", out_port, exp_q.pop_front());
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    step();
    chipselect = 1'b0; write = 1'b0;
  endtask
  task automatic push(input logic [31:0] d, input bit acc);
    if (acc) exp_q.push_back(d);
    wr(2'd0, d);
  endtask
  task automatic rdchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    chipselect = 1'b1; read = 1'b1; address = a;
    step();
    chipselect = 1'b0; read = 1'b0;
    chk(tag, readdata, exp);
  endtask
  task automatic tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
  endtask
  initial begin
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_out_port", out_port, 0);
    chk("rst_strobe", 32'(out_strobe), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_readdata", readdata, 0);
    rdchk("rst_status", 2'd1, 32'h0008_0000);
    rdchk("rst_control", 2'd2, 32'h0);
    push(32'h1111, 1'b1);
    push(32'h2222, 1'b1);
    push(32'h3333, 1'b1);
    rdchk("status_lvl3", 2'd1, 32'h3);
    wr(2'd2, 32'h1);
    tick(); tick(); tick();
    chk("strobes_after_pops", 32'(strobes), 3);
    rdchk("status_lvl0", 2'd1, 32'h0008_0000);
    tick(); tick();
    chk("strobes_underrun", 32'(strobes), 3);
    rdchk("data_held", 2'd0, 32'h3333);
    rdchk("status_udf", 2'd1, 32'h000A_0000);
    rdchk("urun_cnt", 2'd3, 32'h2);
    wr(2'd1, 32'h0002_0000);
    rdchk("status_udf_clr", 2'd1, 32'h0008_0000);
    for (int i = 0; i < 17; i++) push(32'h100 + 32'(i), i < 16);
    rdchk("status_full_ovf", 2'd1, 32'h0005_0010);
    exp_q.push_back(32'hABCD);
    chipselect = 1'b1; write = 1'b1; address = 2'd0; writedata = 32'hABCD; sample_tick = 1'b1;
    step();
    chipselect = 1'b0; write = 1'b0; sample_tick = 1'b0;
    chk("full_pop_strobe", 32'(out_strobe), 1);
    rdchk("status_full_pop", 2'd1, 32'h0005_0010);
    wr(2'd1, 32'h0001_0000);
    for (int i = 0; i < 8; i++) tick();
    rdchk("status_lvl8", 2'd1, 32'h8);
    wr(2'd2, 32'h3);
    exp_q.delete();
    rdchk("status_flush", 2'd1, 32'h0008_0000);
    rdchk("control_flush", 2'd2, 32'h1);
    rdchk("data_flush", 2'd0, 32'h108);
    wr(2'd2, 32'h5);
    for (int i = 0; i < 5; i++) push(32'h200 + 32'(i), 1'b1);
    step();
    chk("irq_lvl5", 32'(irq), 0);
    rdchk("status_lvl5", 2'd1, 32'h5);
    tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("irq_lag", 32'(irq), 0);
    step();
    chk("irq_lvl3", 32'(irq), 1);
    push(32'h205, 1'b1);
    chk("irq_hold", 32'(irq), 1);
    step();
    chk("irq_lvl4", 32'(irq), 0);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("strobe_pre_reset", 32'(out_strobe), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    chk("mid_rst_out_port", out_port, 0);
    chk("mid_rst_strobe", 32'(out_strobe), 0);
    chk("mid_rst_irq", 32'(irq), 0);
    chk("mid_rst_readdata", readdata, 0);
    rdchk("mid_rst_status", 2'd1, 32'h0008_0000);
    rdchk("mid_rst_cnt", 2'd3, 32'h0);
    chk("strobe_total", 32'(strobes), 15);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
